// File: rtl/mpc_qp_admm_coef_row_reader.sv
// Coefficient-ROM row reader: sequences one ROM row and streams it out as valid/ready with a last flag.
// Define MPC_COEF_READER_BOUNDS_EN to reject rows that fall outside the populated ROM range.
module mpc_qp_admm_coef_row_reader #(
    parameter int DataWidth    = 18,
    parameter int AddressWidth = 5,
    parameter int AddressRange = 24,
    parameter int LenWidth     = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [AddressWidth-1:0] base,
    input  logic [LenWidth-1:0]     len,
    output logic                    busy,
    output logic                    done,
    output logic [AddressWidth-1:0] rom_address0,
    output logic                    rom_ce0,
    input  logic [DataWidth-1:0]    rom_q0,
    output logic [DataWidth-1:0]    out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

`ifdef MPC_COEF_READER_BOUNDS_EN
    localparam bit BoundsEn = 1'b1;
`else
    localparam bit BoundsEn = 1'b0;
`endif
    localparam logic [LenWidth:0]     RangeL = (LenWidth+1)'(AddressRange);
    localparam logic [AddressWidth:0] RangeA = (AddressWidth+1)'(AddressRange);

    logic [1:0]              state_q, state_d;
    logic [AddressWidth-1:0] base_q, base_d;
    logic [LenWidth-1:0]     len_q, len_d;
    logic [LenWidth-1:0]     issued_q, issued_d;
    logic                    inflight_q, inflight_last_q;
    logic [DataWidth-1:0]    fifo_data_q [2];
    logic                    fifo_last_q [2];
    logic                    wr_ptr_q, rd_ptr_q;
    logic [1:0]              count_q;
    logic                    start_ok, issue, fifo_empty, push, pop, bounds_bad;
    logic [LenWidth:0]       end_addr;

    assign end_addr   = {1'b0, len} + (LenWidth+1)'(base);
    assign bounds_bad = BoundsEn && ((end_addr > RangeL) || ({1'b0, base} >= RangeA));
    assign start_ok   = start && (state_q == S_IDLE);

    // Never more than two words outstanding, so the 2-entry FIFO cannot overflow.
    assign issue = (state_q == S_RUN) && (issued_q != len_q)
                   && ((count_q + {1'b0, inflight_q}) < 2'd2);

    assign rom_ce0      = issue;
    assign rom_address0 = base_q + AddressWidth'(issued_q);

    // An arriving ROM word bypasses the empty FIFO so the first beat costs no extra cycle.
    assign fifo_empty = (count_q == 2'd0);
    assign out_valid  = !fifo_empty || inflight_q;
    assign out_data   = !fifo_empty ? fifo_data_q[rd_ptr_q] : (inflight_q ? rom_q0 : '0);
    assign out_last   = !fifo_empty ? fifo_last_q[rd_ptr_q] : (inflight_q && inflight_last_q);
    assign push       = inflight_q && !(fifo_empty && out_ready);
    assign pop        = !fifo_empty && out_ready;

    assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done = (state_q == S_FIN);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        issued_d = issued_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok && !bounds_bad) begin
                    base_d   = base;
                    len_d    = len;
                    issued_d = '0;
                    state_d  = (len == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (issue) begin
                    issued_d = issued_q + LenWidth'(1);
                    if (issued_d == len_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_valid && out_ready && out_last) state_d = S_FIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            base_q          <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            count_q         <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && (issued_q == len_q - LenWidth'(1));
            if (push) wr_ptr_q <= !wr_ptr_q;
            if (pop)  rd_ptr_q <= !rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= rom_q0;
            fifo_last_q[wr_ptr_q] <= inflight_last_q;
        end
    end

`ifdef MPC_COEF_READER_BOUNDS_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= start_ok && bounds_bad;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
